// File: rtl/async_fifo_wr_packer.sv
// Write-side packer for the dual-clock FIFO.
// Packs a narrow valid/ready beat stream little-endian into OUT_WIDTH words and
// drives the FIFO write port. Partial words leave on flush_i or after an idle
// timeout, tagged with (lane count - 1) above the data bits.
module async_fifo_wr_packer #(
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned OUT_WIDTH = 32,
  parameter int unsigned TIMEOUT   = 64,
  localparam int unsigned LANES    = OUT_WIDTH / IN_WIDTH,
  localparam int unsigned LW       = $clog2(LANES)
) (
  input  logic                    wclk_i,
  input  logic                    rst_ni,
  input  logic                    in_valid_i,
  input  logic [IN_WIDTH-1:0]     in_data_i,
  output logic                    in_ready_o,
  input  logic                    flush_i,
  output logic [OUT_WIDTH+LW-1:0] fifo_wdata_o,
  output logic                    fifo_we_o,
  input  logic                    fifo_full_i,
  output logic                    idle_o
);

  localparam logic [LW:0] PackFull = (LW+1)'(LANES);

  // Idle timer: counts the cycles a partial word has sat without a new beat.
  // It saturates at TIMEOUT-1, so the hit cycle is the TIMEOUT-th idle cycle.
  localparam bit          TmrEn   = (TIMEOUT > 0);
  localparam int unsigned TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TmrLast = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  // Pack register
  logic [OUT_WIDTH-1:0] pack_data_q, pack_data_d;
  logic [LW:0]          pack_cnt_q,  pack_cnt_d;

  // Output register (drives the FIFO write port directly)
  logic                 out_vld_q,    out_vld_d;
  logic [OUT_WIDTH-1:0] out_data_q,   out_data_d;
  logic [LW-1:0]        out_cnt_m1_q, out_cnt_m1_d;

  // Flush and timer state
  logic                 flush_pend_q, flush_pend_d;
  logic [TW-1:0]        timer_q,      timer_d;

  logic accept;
  logic out_free;
  logic pack_full;
  logic pack_empty;
  logic timer_hit;
  logic flush_req;
  logic move;
  logic beat_acc;

  // Handshake and transfer decisions, all from registered state plus fifo_full_i
  always_comb begin
    pack_full  = (pack_cnt_q == PackFull);
    pack_empty = (pack_cnt_q == '0);
    accept     = out_vld_q & ~fifo_full_i;
    out_free   = ~out_vld_q | accept;
    timer_hit  = TmrEn & ~pack_empty & (timer_q == TmrLast);
    flush_req  = flush_pend_q | timer_hit;
    move       = out_free & (pack_full | (flush_req & ~pack_empty));
    in_ready_o = ~flush_pend_q & (~pack_full | out_free);
    beat_acc   = in_valid_i & in_ready_o;
  end

  // Pack register next state: a move empties it, a beat fills the next lane
  always_comb begin
    pack_data_d = pack_data_q;
    pack_cnt_d  = pack_cnt_q;
    if (move) begin
      pack_data_d = '0;
      pack_cnt_d  = '0;
      if (beat_acc) begin
        pack_data_d[IN_WIDTH-1:0] = in_data_i;
        pack_cnt_d                = (LW+1)'(1);
      end
    end else if (beat_acc) begin
      // Without a move the pack cannot be full here, so lane pack_cnt_q exists
      for (int unsigned k = 0; k < LANES; k++) begin
        if (pack_cnt_q == (LW+1)'(k)) begin
          pack_data_d[k*IN_WIDTH +: IN_WIDTH] = in_data_i;
        end
      end
      pack_cnt_d = pack_cnt_q + (LW+1)'(1);
    end
  end

  // Output register next state: load on move, release on FIFO accept
  always_comb begin
    out_vld_d    = out_vld_q;
    out_data_d   = out_data_q;
    out_cnt_m1_d = out_cnt_m1_q;
    if (move) begin
      out_vld_d    = 1'b1;
      out_data_d   = pack_data_q;
      out_cnt_m1_d = LW'(pack_cnt_q - (LW+1)'(1));
    end else if (accept) begin
      out_vld_d = 1'b0;
    end
  end

  // Flush request and idle timer next state
  always_comb begin
    flush_pend_d = flush_pend_q;
    if (flush_pend_q && (move || pack_empty)) begin
      // Clearing wins over a repeated flush_i in the same cycle
      flush_pend_d = 1'b0;
    end else if (flush_i) begin
      flush_pend_d = 1'b1;
    end

    timer_d = timer_q;
    if (beat_acc || move) begin
      timer_d = '0;
    end else if (TmrEn && !pack_empty && (timer_q != TmrLast)) begin
      timer_d = timer_q + TW'(1);
    end
  end

  // State registers, cleared asynchronously; a reset discards any partial word
  always_ff @(posedge wclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pack_data_q  <= '0;
      pack_cnt_q   <= '0;
      out_vld_q    <= 1'b0;
      out_data_q   <= '0;
      out_cnt_m1_q <= '0;
      flush_pend_q <= 1'b0;
      timer_q      <= '0;
    end else begin
      pack_data_q  <= pack_data_d;
      pack_cnt_q   <= pack_cnt_d;
      out_vld_q    <= out_vld_d;
      out_data_q   <= out_data_d;
      out_cnt_m1_q <= out_cnt_m1_d;
      flush_pend_q <= flush_pend_d;
      timer_q      <= timer_d;
    end
  end

  // FIFO write port and idle status
  always_comb begin
    fifo_we_o    = out_vld_q;
    fifo_wdata_o = {out_cnt_m1_q, out_data_q};
    idle_o       = pack_empty & ~out_vld_q & ~flush_pend_q;
  end

endmodule
